// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/HOLD control and a one-cycle terminal-count pulse.
// Latency: all outputs registered; a start accepted at edge S gives out=N-k after edge S+k.
// Optional feature: define COUNTDOWN_TIMER_AUTORELOAD_EN for periodic reload at terminal count.
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // Next-state logic; priority within each state is stop > load > start > count.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (stop) begin
          // nothing to pause while idle
        end else if (load) begin
          out_d    = load_value;
          reload_d = load_value;
        end else if (start) begin
          if (out_q != ZERO) begin
            state_d = RUN;
          end else begin
            // starting an expired timer reports terminal count immediately
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_d = HOLD;
        end else if (load) begin
          out_d    = load_value;
          reload_d = load_value;
        end else if (enable) begin
          if (out_q == ONE) begin
            done_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            if (reload_q != ZERO) begin
              out_d = reload_q;
            end else begin
              out_d   = ZERO;
              state_d = IDLE;
            end
`else
            out_d   = ZERO;
            state_d = IDLE;
`endif
          end else if (out_q != ZERO) begin
            out_d = out_q - ONE;
          end
          // out==0 in RUN (loaded zero) simply holds: the count never wraps
        end
      end
      HOLD: begin
        if (stop) begin
          // already paused
        end else if (load) begin
          out_d    = load_value;
          reload_d = load_value;
          state_d  = IDLE;
        end else if (start) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // busy is registered from the next state so it tracks state with no extra lag
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      out_q    <= ZERO;
      reload_q <= ZERO;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign out  = out_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed, table-driven bench for countdown_timer plus a hand-written done-timing sequence.
// Inputs driven on the falling edge; outputs sampled 1 time unit after the rising edge.
// Covers the default one-shot build, or the auto-reload build when its macro is defined.
module tb_countdown_timer;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         load;
  logic [W-1:0] load_value;
  logic         start;
  logic         stop;
  logic [W-1:0] out;
  logic         done;
  logic         busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         rst;
    logic         en;
    logic         ld;
    logic [W-1:0] lv;
    logic         st;
    logic         sp;
    logic [W-1:0] e_out;
    logic         e_done;
    logic         e_busy;
  } vec_t;

  vec_t vecs[$];

  countdown_timer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .out        (out),
    .done       (done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic en, input logic ld, input logic [W-1:0] lv,
                     input logic st, input logic sp, input logic [W-1:0] eo,
                     input logic ed, input logic eb);
    vec_t v;
    v.rst = rst; v.en = en; v.ld = ld; v.lv = lv; v.st = st; v.sp = sp;
    v.e_out = eo; v.e_done = ed; v.e_busy = eb;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic en, input logic ld, input logic [W-1:0] lv,
                       input logic st, input logic sp);
    @(negedge clk);
    reset = rst; enable = en; load = ld; load_value = lv; start = st; stop = sp;
  endtask

  task automatic check(input string name, input int idx, input logic [W-1:0] eo,
                       input logic ed, input logic eb);
    checks++;
    if (out !== eo || done !== ed || busy !== eb) begin
      errors++;
      $display("FAIL %s[%0d]: got out=%0d done=%b busy=%b, want out=%0d done=%b busy=%b",
               name, idx, out, done, busy, eo, ed, eb);
    end
  endtask

  initial begin
    int cyc;
    bit seen;
    reset = 1'b1; enable = 1'b0; load = 1'b0; load_value = '0; start = 1'b0; stop = 1'b0;

    //   rst en ld lv st sp   out done busy
    add(1, 0, 0, 0, 0, 0,   0, 0, 0);      // reset state
`ifndef COUNTDOWN_TIMER_AUTORELOAD_EN
    // load 5, start, count down to terminal
    add(0, 0, 1, 5, 0, 0,   5, 0, 0);
    add(0, 1, 0, 0, 1, 0,   5, 0, 1);      // enable ignored in IDLE
    add(0, 1, 0, 0, 0, 0,   4, 0, 1);
    add(0, 1, 0, 0, 0, 0,   3, 0, 1);
    add(0, 1, 0, 0, 0, 0,   2, 0, 1);
    add(0, 1, 0, 0, 0, 0,   1, 0, 1);
    add(0, 1, 0, 0, 0, 0,   0, 1, 0);      // terminal: done and busy fall together
    add(0, 1, 0, 0, 0, 0,   0, 0, 0);      // single pulse, no wrap
    // load 3, enable low for two cycles mid-count
    add(0, 0, 1, 3, 0, 0,   3, 0, 0);
    add(0, 1, 0, 0, 1, 0,   3, 0, 1);
    add(0, 1, 0, 0, 0, 0,   2, 0, 1);
    add(0, 0, 0, 0, 0, 0,   2, 0, 1);
    add(0, 0, 0, 0, 0, 0,   2, 0, 1);
    add(0, 1, 0, 0, 0, 0,   1, 0, 1);
    add(0, 1, 0, 0, 0, 0,   0, 1, 0);      // 5 cycles after start
    // load 10, stop after 4 decrements, resume
    add(0, 0, 1, 10, 0, 0, 10, 0, 0);
    add(0, 1, 0, 0, 1, 0,  10, 0, 1);
    add(0, 1, 0, 0, 0, 0,   9, 0, 1);
    add(0, 1, 0, 0, 0, 0,   8, 0, 1);
    add(0, 1, 0, 0, 0, 0,   7, 0, 1);
    add(0, 1, 0, 0, 0, 0,   6, 0, 1);
    add(0, 1, 0, 0, 0, 1,   6, 0, 1);      // stop -> HOLD
    add(0, 1, 0, 0, 0, 0,   6, 0, 1);      // enable has no effect in HOLD
    add(0, 1, 0, 0, 1, 0,   6, 0, 1);      // resume
    add(0, 1, 0, 0, 0, 0,   5, 0, 1);
    add(0, 1, 0, 0, 0, 0,   4, 0, 1);
    add(0, 1, 0, 0, 0, 0,   3, 0, 1);
    add(0, 1, 0, 0, 0, 0,   2, 0, 1);
    add(0, 1, 0, 0, 0, 0,   1, 0, 1);
    add(0, 1, 0, 0, 0, 0,   0, 1, 0);
    // start with out==0 in IDLE
    add(0, 0, 0, 0, 1, 0,   0, 1, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0);
    // load and start together: load only
    add(0, 1, 1, 9, 1, 0,   9, 0, 0);
    add(0, 1, 0, 0, 0, 0,   9, 0, 0);
    add(0, 1, 0, 0, 1, 0,   9, 0, 1);
    add(0, 1, 0, 0, 0, 0,   8, 0, 1);
    add(0, 1, 0, 0, 0, 0,   7, 0, 1);
    // reset mid-count at out=7
    add(1, 1, 0, 0, 0, 0,   0, 0, 0);
    add(0, 1, 0, 0, 1, 0,   0, 1, 0);
    add(0, 1, 0, 0, 0, 0,   0, 0, 0);
    // stop coincident with terminal count
    add(0, 0, 1, 2, 0, 0,   2, 0, 0);
    add(0, 1, 0, 0, 1, 0,   2, 0, 1);
    add(0, 1, 0, 0, 0, 0,   1, 0, 1);
    add(0, 1, 0, 0, 0, 1,   1, 0, 1);      // stop wins, no done
    add(0, 0, 1, 3, 0, 0,   3, 0, 0);      // load in HOLD -> IDLE
    // load in RUN replaces count without decrement
    add(0, 1, 0, 0, 1, 0,   3, 0, 1);
    add(0, 1, 0, 0, 0, 0,   2, 0, 1);
    add(0, 1, 1, 6, 0, 0,   6, 0, 1);
    add(0, 1, 0, 0, 0, 0,   5, 0, 1);
    add(0, 1, 1, 8, 0, 1,   5, 0, 1);      // stop beats load
    add(0, 1, 1, 4, 1, 0,   4, 0, 0);      // load beats start in HOLD
`else
    // auto-reload: load 4, start, 12 enabled cycles
    add(0, 0, 1, 4, 0, 0,   4, 0, 0);
    add(0, 1, 0, 0, 1, 0,   4, 0, 1);
    for (int p = 0; p < 3; p++) begin
      add(0, 1, 0, 0, 0, 0, 3, 0, 1);
      add(0, 1, 0, 0, 0, 0, 2, 0, 1);
      add(0, 1, 0, 0, 0, 0, 1, 0, 1);
      add(0, 1, 0, 0, 0, 0, 4, 1, 1);
    end
    add(0, 1, 0, 0, 0, 1,   4, 0, 1);      // stop -> HOLD
    add(0, 0, 1, 0, 0, 0,   0, 0, 0);      // load 0 in HOLD -> IDLE
    add(0, 0, 0, 0, 1, 0,   0, 1, 0);      // start at zero: done only
    add(0, 0, 0, 0, 0, 0,   0, 0, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].sp);
      @(posedge clk);
      #1;
      check("vec", i, vecs[i].e_out, vecs[i].e_done, vecs[i].e_busy);
    end

    // Hand sequence: from reset, load 3 and start; done must arrive exactly 3 edges later
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 3, 0, 0);
    drive(0, 1, 0, 0, 1, 0);
    @(posedge clk); #1;
    check("seq_start", 0, 3, 0, 1);
    drive(0, 1, 0, 0, 0, 0);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || cyc != 3) begin
      errors++;
      $display("FAIL seq_done_latency: got seen=%0d cycles=%0d, want seen=1 cycles=3", seen, cyc);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL seq_done_width: got done=%b, want done=0", done);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with a start/stop control FSM and a one-cycle terminal-count pulse. Complements the free-running up-counter: it counts from a programmed value toward zero instead of up from zero. It sits beside the counter in the timing subsystem and supplies timeouts and periodic ticks. The block never wraps below zero.

## Interface
Parameters:
- WIDTH, 8, width of count and load value.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count qualifier; decrement only when high.
- load  input  1  capture load_value into count and reload register.
- load_value  input  WIDTH  value captured on load.
- start  input  1  begin or resume counting.
- stop  input  1  pause counting.
- out  output  WIDTH  current count, registered.
- done  output  1  one-cycle terminal-count pulse, registered.
- busy  output  1  high in RUN and HOLD, registered.

## Operation
- Internal reload register (WIDTH), written only on an accepted load.
- States: IDLE, RUN, HOLD.
- Reset values: out=0, done=0, busy=0, reload=0, state IDLE.
- Input priority at each edge: reset > stop > load > start > count.
- IDLE:
  - load: out<=load_value, reload<=load_value.
  - start with out!=0: go to RUN.
  - start with out==0: done=1 for one cycle; stay IDLE.
  - enable is ignored.
- RUN:
  - enable=1: out<=out-1.
  - enable=0: out holds; stay RUN.
  - stop: go to HOLD; out holds.
  - load: out<=load_value, reload<=load_value; stay RUN; no decrement that cycle.
  - start: ignored.
- Terminal count (RUN, enable=1, out==1):
  - out<=0 and done<=1 on the same edge.
  - Next state: IDLE, or as modified by Configuration.
- HOLD:
  - start: go to RUN.
  - load: out<=load_value, reload<=load_value; go to IDLE.
  - stop, enable: no effect.
- done is high for exactly one cycle per terminal event.
- out never goes below 0. There is no modular arithmetic.

## Timing
- All outputs are registered. Each output changes only on a rising clk edge.
- busy follows state with no extra delay: it is high in the cycle after the edge that enters RUN.
- Load of N at edge L, start at edge S>L, enable held high:
  - out=N-k after edge S+k.
  - done=1 after edge S+N only.
  - busy=0 after edge S+N when auto-reload is disabled.
- Each enable=0 cycle in RUN delays terminal count by one cycle.
- load and start in the same cycle:
  - load wins and start is ignored.
  - Counting needs a later start.
- stop and terminal count in the same cycle: stop wins. out stays 1, state goes to HOLD, done=0.
- reset mid-count: the next edge forces the full reset state and loses the reload value.

## Configuration
- Macro COUNTDOWN_TIMER_AUTORELOAD_EN.
- Defined: at terminal count, out<=reload and done<=1, and state stays RUN. This gives a periodic done every reload cycles while enable=1.
  - If reload==0: behave as if undefined (out<=0, go to IDLE).
- Undefined: at terminal count, out<=0 and the FSM returns to IDLE. The block is one-shot.

## Test plan
- Reset, then load 5 and start with enable=1 -> out reads 4,3,2,1,0 on successive edges; done high exactly once, coincident with out=0; busy falls on the same edge.
- Load 3, start, then enable low for 2 cycles mid-count -> out freezes during those cycles; done arrives 5 cycles after start.
- Load 10, start, stop after 4 decrements -> out=6, busy=1, no done; start again -> done 6 cycles later.
- Start with out=0 in IDLE -> done pulses one cycle; busy stays 0. Load and start asserted together -> only the load takes effect.
- Assert reset while out=7 in RUN -> next edge gives out=0, done=0, busy=0; a following start gives a done pulse only.
- With COUNTDOWN_TIMER_AUTORELOAD_EN defined, load 4, start, enable high for 12 cycles -> done pulses at edges 4, 8 and 12 after start; busy stays 1 throughout.
